// File: rtl/byte_serial_add32_pkg.sv
// Shared constants for the byte-serial 32-bit adder: FSM encoding, widths,
// and the carry-lookahead carry equation used by the 8-bit slice.
package byte_serial_add32_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NBYTES = WIDTH / SLICE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Carry into bit n as a flat sum of products: every generate term j<n
    // propagated through bits j+1..n-1, plus c0 propagated through 0..n-1.
    function automatic logic cla_carry(input logic [SLICE-1:0] g,
                                       input logic [SLICE-1:0] p,
                                       input logic             c0,
                                       input int               n);
        logic res;
        logic term;
        res = 1'b0;
        for (int j = 0; j < n; j++) begin
            term = g[j];
            for (int k = j + 1; k < n; k++) begin
                term = term & p[k];
            end
            res = res | term;
        end
        term = c0;
        for (int k = 0; k < n; k++) begin
            term = term & p[k];
        end
        return res | term;
    endfunction

endpackage

// File: rtl/byte_serial_add32_adder_8.sv
// 8-bit carry-lookahead adder slice; every carry is formed directly from the
// generate/propagate terms rather than rippling bit to bit.
module adder_8
    import byte_serial_add32_pkg::*;
(
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] s_o,
    output logic             c_o
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    assign g    = a_i & b_i;
    assign p    = a_i ^ b_i;
    assign c[0] = c_i;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_carry
            assign c[gi+1] = cla_carry(g, p, c_i, gi + 1);
        end
    endgenerate

    assign s_o = p ^ c[SLICE-1:0];
    assign c_o = c[SLICE];

endmodule

// File: rtl/byte_serial_add32.sv
// 32-bit add/subtract computed one byte per cycle through a single 8-bit
// lookahead slice; result and flags appear together at the end of RUN.
module byte_serial_add32
    import byte_serial_add32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q, zero_q;

    logic             capture;
    logic             step;
    logic [SLICE-1:0] a_byte, b_byte, sum_byte;
    logic             slice_co;
    logic [WIDTH-1:0] res_d;
    logic [4:0]       bit_base;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == 2'd3) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        capture = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE:    capture = start;
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                capture = start;
            end
            default: ;
        endcase
    end

    assign bit_base = {idx_q, 3'b000};
    assign a_byte   = a_q[bit_base +: SLICE];
    assign b_byte   = b_q[bit_base +: SLICE];

    adder_8 u_adder_8 (
        .a_i (a_byte),
        .b_i (b_byte),
        .c_i (carry_q),
        .s_o (sum_byte),
        .c_o (slice_co)
    );

    assign res_d = {sum_byte, part_q[WIDTH-SLICE-1:0]};

    // Datapath: operand capture, per-byte accumulation, final result load.
    // b is stored already inverted for subtraction so the slice only adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (capture) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= 2'd0;
        end else if (step) begin
            part_q[bit_base +: SLICE] <= sum_byte;
            carry_q <= slice_co;
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                s_q    <= res_d;
                cout_q <= slice_co;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_q <= (res_d == '0);
            end
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_byte_serial_add32.sv
// Directed and random checks of byte_serial_add32 against a plain-arithmetic
// reference (33-bit unsigned sum, 64-bit signed sum for overflow).
module tb_byte_serial_add32;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst, start, cin, sub;
    logic [31:0] a, b, s;
    logic        cout, ovf, zero, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_s;
    logic [2:0]  exp_f;

    byte_serial_add32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin,
                         input logic tsub, output logic [31:0] rs, output logic [2:0] rf);
        logic [32:0] wide;
        longint      sr;
        logic        rc, ro;
        if (tsub) begin
            rs = ta - tb_;
            rc = (ta >= tb_);
            sr = longint'($signed(ta)) - longint'($signed(tb_));
        end else begin
            wide = 33'(ta) + 33'(tb_) + 33'(tcin);
            rs   = wide[31:0];
            rc   = wide[32];
            sr   = longint'($signed(ta)) + longint'($signed(tb_)) + longint'(tcin);
        end
        ro = (sr > SMAX) || (sr < SMIN);
        rf = {rc, ro, (rs == 32'd0)};
    endtask

    // One full operation starting from IDLE or DONE; inputs are scrambled
    // after the capture edge and the old result must stay on s during RUN.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin, input logic tsub);
        logic [31:0] ns;
        logic [2:0]  nf;
        model(ta, tb_, tcin, tsub, ns, nf);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            chk("run_busy_done", {30'd0, busy, done}, 32'd2);
            chk("run_s_hold", s, exp_s);
            tick();
        end
        exp_s = ns;
        exp_f = nf;
        chk("done_pulse", {30'd0, busy, done}, 32'd1);
        chk("result_s", s, exp_s);
        chk("result_flags", {29'd0, cout, ovf, zero}, {29'd0, exp_f});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        exp_s = '0; exp_f = '0;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        chk("reset_s", s, 32'd0);
        chk("reset_flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        chk("dir_ff_plus_1", s, 32'h00000100);
        tick();
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        chk("dir_wrap_flags", {29'd0, cout, ovf, zero}, 32'd5);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        chk("dir_pos_ovf", {s[31:0]}, 32'h80000000);
        chk("dir_pos_ovf_flags", {29'd0, cout, ovf, zero}, 32'd2);
        run_op(32'd5, 32'd7, 1'b1, 1'b1);
        chk("dir_sub_borrow", s, 32'hFFFFFFFE);
        chk("dir_sub_borrow_cout", {31'd0, cout}, 32'd0);
        run_op(32'h80000000, 32'd1, 1'b0, 1'b1);
        chk("dir_sub_ovf", s, 32'h7FFFFFFF);
        chk("dir_sub_ovf_flags", {29'd0, cout, ovf, zero}, 32'd6);
        tick();

        // start pulsed on RUN edges 2 and 3 must be ignored
        a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 32'd1000; b = 32'd1000;
        tick();
        chk("ign_start_e2", {30'd0, busy, done}, 32'd2);
        tick();
        chk("ign_start_e3", {30'd0, busy, done}, 32'd2);
        start = 1'b0;
        tick();
        chk("ign_done", {30'd0, busy, done}, 32'd1);
        chk("ign_s", s, 32'd7);
        tick();
        chk("ign_single_done", {30'd0, busy, done}, 32'd0);
        chk("ign_s_hold", s, 32'd7);

        // start held through DONE: back-to-back capture, done 5 cycles apart
        a = 32'd10; b = 32'd20; start = 1'b1;
        tick();
        a = 32'd100; b = 32'd200;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("b2b_run1", {30'd0, busy, done}, 32'd2);
        end
        tick();
        chk("b2b_done1", {30'd0, busy, done}, 32'd1);
        chk("b2b_s1", s, 32'd30);
        tick();
        start = 1'b0;
        for (int k = 5; k < 9; k++) begin
            chk("b2b_run2", {30'd0, busy, done}, 32'd2);
            tick();
        end
        chk("b2b_done2", {30'd0, busy, done}, 32'd1);
        chk("b2b_s2", s, 32'd300);
        tick();

        // reset on the third RUN edge aborts without a done pulse
        a = 32'hAAAA5555; b = 32'h1234ABCD; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_s", s, 32'd0);
        exp_s = '0; exp_f = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_no_done", {30'd0, busy, done}, 32'd0);
        end
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        chk("post_rst_s", s, 32'h23456789);

        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk("rand_idle", {30'd0, busy, done}, 32'd0);
            end
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
